// File: rtl/spy_pkg.sv
// Shared types and default widths for the spy buffer readout path
// (memory block and freeze reader).
package spy_pkg;

    localparam int SPY_ADDR_WIDTH = 6;
    localparam int SPY_DATA_WIDTH = 64;

    // Fill value for header bits above the count/address fields and for idle out_data.
    localparam logic SPY_HDR_ZERO_PAD = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_HEADER,
        S_ISSUE,
        S_PRESENT,
        S_DONE
    } spy_reader_state_t;

endpackage

// File: rtl/spy_freeze_reader_if.sv
// Readout stream (valid/ready with last marker) from the freeze reader
// toward the readout/IPbus side.
interface spy_freeze_reader_if
    import spy_pkg::*;
#(
    parameter int DATA_WIDTH = SPY_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/spy_occupancy_counter.sv
// Saturating up-counter of valid words in the spy buffer, 0..2**ADDR_WIDTH.
module spy_occupancy_counter
    import spy_pkg::*;
#(
    parameter int ADDR_WIDTH = SPY_ADDR_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                count_enable,
    output logic [ADDR_WIDTH:0] count
);
    localparam logic [ADDR_WIDTH:0] SIZE = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;

    // NOTE: reset is synchronous and active-low, so it is tested inside the
    // clocked branch; state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (count_enable && (count != SIZE)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/spy_freeze_reader.sv
// Freezes the spy buffer on request and streams its history out, oldest word first.
// Define SPY_READER_HEADER_EN to prefix each readout with a {start addr, count} header word.
module spy_freeze_reader
    import spy_pkg::*;
#(
    parameter int ADDR_WIDTH = SPY_ADDR_WIDTH,
    parameter int DATA_WIDTH = SPY_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  freeze_req,
    input  logic                  mem_write_enable,
    input  logic [ADDR_WIDTH-1:0] mem_write_pointer,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic                  mem_read_enable,
    output logic                  freeze,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   occupancy,
    spy_freeze_reader_if.master   stream
);
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam int HDR_PAD   = DATA_WIDTH - ADDR_WIDTH - CNT_WIDTH;

    spy_reader_state_t     state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [DATA_WIDTH-1:0] header_word;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  handshake;

    spy_occupancy_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_occupancy (
        .clock        (clock),
        .reset        (reset),
        .count_enable (mem_write_enable && (state == S_IDLE)),
        .count        (occupancy)
    );

    // A full buffer drops the MSB of occupancy, leaving start == write pointer.
    assign start_addr  = mem_write_pointer - occupancy[ADDR_WIDTH-1:0];
    assign header_word = {{HDR_PAD{SPY_HDR_ZERO_PAD}}, addr, cnt};
    assign handshake   = out_valid_q && stream.out_ready;

    assign freeze           = (state != S_IDLE);
    assign stream.out_valid = out_valid_q;
    assign stream.out_last  = out_last_q;

    // The memory holds its read data while read_enable is low, so data beats pass straight through.
    always_comb begin
        stream.out_data = {DATA_WIDTH{SPY_HDR_ZERO_PAD}};
        if (out_valid_q) begin
            stream.out_data = (state == S_HEADER) ? header_word : mem_read_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            addr            <= '0;
            mem_read_enable <= 1'b0;
            mem_read_addr   <= '0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (freeze_req) state <= S_SNAP;
                end
                S_SNAP: begin
                    cnt  <= occupancy;
                    addr <= start_addr;
`ifdef SPY_READER_HEADER_EN
                    state       <= S_HEADER;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (occupancy == '0);
`else
                    if (occupancy == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state           <= S_ISSUE;
                        mem_read_enable <= 1'b1;
                        mem_read_addr   <= start_addr;
                    end
`endif
                end
`ifdef SPY_READER_HEADER_EN
                S_HEADER: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (cnt == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state           <= S_ISSUE;
                            mem_read_enable <= 1'b1;
                            mem_read_addr   <= addr;
                        end
                    end
                end
`endif
                S_ISSUE: begin
                    mem_read_enable <= 1'b0;
                    out_valid_q     <= 1'b1;
                    out_last_q      <= (cnt == CNT_WIDTH'(1));
                    state           <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        addr        <= addr + 1'b1;
                        cnt         <= cnt - 1'b1;
                        if (cnt == CNT_WIDTH'(1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state           <= S_ISSUE;
                            mem_read_enable <= 1'b1;
                            mem_read_addr   <= addr + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spy_freeze_reader.sv
// Self-checking bench for spy_freeze_reader: a memory model plus a history-queue reference,
// with randomized data and backpressure; honours SPY_READER_HEADER_EN.
module tb_spy_freeze_reader;
    localparam int AW   = 4;
    localparam int DW   = 64;
    localparam int SIZE = 1 << AW;
`ifdef SPY_READER_HEADER_EN
    localparam int FIRST_LAT = 2;
`else
    localparam int FIRST_LAT = 3;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          freeze_req = 1'b0;
    logic          mem_write_enable = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] wptr;
    logic [DW-1:0] mem_read_data;
    logic [AW-1:0] mem_read_addr;
    logic          mem_read_enable;
    logic          freeze;
    logic          done;
    logic [AW:0]   occupancy;
    logic [DW-1:0] mem [SIZE];

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] hist [$];

    spy_freeze_reader_if #(.DATA_WIDTH(DW)) stream ();

    spy_freeze_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock             (clock),
        .reset             (reset),
        .freeze_req        (freeze_req),
        .mem_write_enable  (mem_write_enable),
        .mem_write_pointer (wptr),
        .mem_read_data     (mem_read_data),
        .mem_read_addr     (mem_read_addr),
        .mem_read_enable   (mem_read_enable),
        .freeze            (freeze),
        .done              (done),
        .occupancy         (occupancy),
        .stream            (stream)
    );

    always #5 clock = ~clock;

    // Circular spy memory: writes gated by freeze, 1-cycle registered read that holds its data.
    always @(posedge clock) begin
        if (!reset) wptr <= '0;
        else if (mem_write_enable && !freeze) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + 1'b1;
        end
        if (mem_read_enable) mem_read_data <= mem[mem_read_addr];
    end

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        freeze_req = 1'b0;
        mem_write_enable = 1'b0;
        stream.out_ready = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b1;
        hist.delete();
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem_write_enable = 1'b1;
            wdata = rand_word();
            hist.push_back(wdata);
            @(posedge clock); #1;
        end
        mem_write_enable = 1'b0;
    endtask

    // Requests a freeze and follows the readout to its end, checking every beat
    // against the last min(history,SIZE) written words.
    task automatic readout(input string tag, input int ready_pct, input bit with_write,
                           input bit noise_writes, input bit refreeze, input int abort_after);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] held;
        int n, start, first_it, last_hs, beats;
        bit stalled, done_seen, rd_seen;
        freeze_req = 1'b1;
        if (with_write) begin
            mem_write_enable = 1'b1;
            wdata = rand_word();
            hist.push_back(wdata);
        end
        n     = (hist.size() > SIZE) ? SIZE : hist.size();
        start = (hist.size() - n) % SIZE;
        for (int i = hist.size() - n; i < hist.size(); i++) exp_q.push_back(hist[i]);
`ifdef SPY_READER_HEADER_EN
        begin
            logic [DW-1:0] hdr;
            hdr = '0;
            hdr[AW:0] = (AW + 1)'(n);
            hdr[2*AW:AW+1] = AW'(start);
            exp_q.push_front(hdr);
        end
`endif
        stream.out_ready = 1'b0;
        first_it = -1; last_hs = -1; beats = 0;
        stalled = 0; done_seen = 0; rd_seen = 0; held = '0;
        for (int it = 1; it <= 300; it++) begin
            @(posedge clock); #1;
            if (done_seen) begin
                n_cmp++;
                if (freeze !== 1'b0 || done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s after_done: freeze=%b done=%b, want 0/0", tag, freeze, done);
                end
                freeze_req = 1'b0; mem_write_enable = 1'b0; stream.out_ready = 1'b0;
                break;
            end
            if (abort_after > 0 && beats == abort_after) return;
            freeze_req = refreeze && (it == 5);
            mem_write_enable = noise_writes;
            if (noise_writes) wdata = rand_word();
            n_cmp++;
            if (freeze !== 1'b1) begin
                n_bad++;
                $display("FAIL %s freeze_busy it=%0d: freeze=%b, want 1", tag, it, freeze);
            end
            if (mem_read_enable && !rd_seen) begin
                rd_seen = 1;
                n_cmp++;
                if (mem_read_addr !== AW'(start)) begin
                    n_bad++;
                    $display("FAIL %s start_addr: got %0d, want %0d", tag, mem_read_addr, start);
                end
            end
            if (stalled) begin
                n_cmp++;
                if (stream.out_valid !== 1'b1 || stream.out_data !== held) begin
                    n_bad++;
                    $display("FAIL %s stall_hold it=%0d: valid=%b data=%h, want 1 %h",
                             tag, it, stream.out_valid, stream.out_data, held);
                end
            end
            if (done) begin
                done_seen = 1;
                n_cmp++;
                if (it != ((exp_q.size() == 0) ? 2 : last_hs + 1) || stream.out_valid) begin
                    n_bad++;
                    $display("FAIL %s done_timing: done at it=%0d valid=%b, last handshake it=%0d",
                             tag, it, stream.out_valid, last_hs);
                end
            end
            stalled = 0;
            stream.out_ready = ($urandom_range(0, 99) < ready_pct);
            if (stream.out_valid) begin
                if (first_it < 0) begin
                    first_it = it;
                    if (ready_pct == 100) begin
                        n_cmp++;
                        if (first_it != FIRST_LAT) begin
                            n_bad++;
                            $display("FAIL %s first_valid: got %0d cycles, want %0d", tag, first_it, FIRST_LAT);
                        end
                    end
                end
                if (stream.out_ready) begin
                    n_cmp++;
                    if (beats >= exp_q.size()) begin
                        n_bad++;
                        $display("FAIL %s extra_beat: beat %0d data=%h, want only %0d beats",
                                 tag, beats, stream.out_data, exp_q.size());
                    end else if (stream.out_data !== exp_q[beats] ||
                                 stream.out_last !== (beats == exp_q.size() - 1)) begin
                        n_bad++;
                        $display("FAIL %s beat%0d: data=%h last=%b, want %h %b", tag, beats,
                                 stream.out_data, stream.out_last, exp_q[beats], beats == exp_q.size() - 1);
                    end
                    if (ready_pct == 100) begin
                        n_cmp++;
                        if (it != first_it + 2 * beats) begin
                            n_bad++;
                            $display("FAIL %s beat_spacing: beat %0d at it=%0d, want %0d",
                                     tag, beats, it, first_it + 2 * beats);
                        end
                    end
                    beats++;
                    last_hs = it;
                end else begin
                    stalled = 1;
                    held = stream.out_data;
                end
            end
        end
        n_cmp++;
        if (!done_seen || beats != exp_q.size() || rd_seen != (n > 0)) begin
            n_bad++;
            $display("FAIL %s completion: done=%b beats=%0d read=%b, want 1 %0d %b",
                     tag, done_seen, beats, rd_seen, exp_q.size(), n > 0);
        end
        n_cmp++;
        if (occupancy !== (AW + 1)'(n)) begin
            n_bad++;
            $display("FAIL %s occupancy_kept: got %0d, want %0d", tag, occupancy, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        freeze_req = 1'b1;
        mem_write_enable = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        n_cmp++;
        if ({freeze, stream.out_valid, stream.out_last, done, mem_read_enable} !== 5'b0 ||
            mem_read_addr !== '0 || occupancy !== '0) begin
            n_bad++;
            $display("FAIL reset_state: frz=%b v=%b l=%b d=%b re=%b ra=%0d occ=%0d, want all 0",
                     freeze, stream.out_valid, stream.out_last, done, mem_read_enable, mem_read_addr, occupancy);
        end
        do_reset();
    endtask

    task automatic test_empty();
        do_reset();
        readout("empty", 100, 0, 0, 0, 0);
    endtask

    task automatic test_partial_fill();
        do_reset();
        write_words(5);
        readout("partial", 100, 0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        readout("simul", 100, 1, 0, 0, 0);
    endtask

    task automatic test_wrap();
        do_reset();
        write_words(20);
        n_cmp++;
        if (occupancy !== (AW + 1)'(SIZE)) begin
            n_bad++;
            $display("FAIL wrap_occupancy: got %0d, want %0d", occupancy, SIZE);
        end
        readout("wrap", 100, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        do_reset();
        write_words(3);
        readout("backpressure", 50, 0, 0, 0, 0);
    endtask

    task automatic test_refreeze();
        do_reset();
        write_words(5);
        readout("frz_writes", 100, 0, 1, 1, 0);
        readout("reread", 70, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_words(5);
        readout("rst_mid", 100, 0, 0, 0, 2);
        reset = 1'b0;
        @(posedge clock); #1;
        n_cmp++;
        if ({freeze, stream.out_valid, stream.out_last, done, mem_read_enable} !== 5'b0 ||
            mem_read_addr !== '0 || occupancy !== '0 || stream.out_data !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_clear: frz=%b v=%b l=%b d=%b re=%b ra=%0d occ=%0d, want all 0",
                     freeze, stream.out_valid, stream.out_last, done, mem_read_enable, mem_read_addr, occupancy);
        end
        reset = 1'b1;
        hist.delete();
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            n_cmp++;
            if (done !== 1'b0 || freeze !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mid_quiet: done=%b freeze=%b, want 0/0", done, freeze);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 6; r++) begin
            write_words($urandom_range(0, 12));
            readout("random", 70, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_partial_fill();
        test_simultaneous();
        test_wrap();
        test_backpressure();
        test_refreeze();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
